sprite_layer_renderer: RTL and testbench
========================================

# sprite_layer_renderer

Parametrised sprite layer for the VGA pipeline. It places an animated, optionally mirrored and integer-scaled sprite at a runtime screen position, drives an external palette-index ROM, and emits a transparency-qualified palette index for the layer compositor. Position and mode are latched once per video frame, so the sprite never tears. The block sits between the DrawX/DrawY scan generator and the palette/priority mux.

## Interface
Parameters:
- SPR_W, 32: sprite width in source pixels (power of two)
- SPR_H, 32: sprite height in source pixels (power of two)
- FRAMES, 2: animation frames stored back-to-back in ROM
- IDX_W, 3: palette index width
- ADDR_W, 11: ROM address width; must satisfy 2^ADDR_W ≥ SPR_W*SPR_H*FRAMES
- SCALE_SHIFT, 0: on-screen scale factor = 2^SCALE_SHIFT
- ANIM_DIV, 8: video frames per animation step (≥1)
- TRANSP_IDX, 0: palette index treated as transparent

Ports:
- vga_clk  in  1  pixel clock; sole clock
- Reset  in  1  synchronous, active-high reset
- DrawX  in  10  current pixel column
- DrawY  in  10  current pixel row
- blank  in  1  1 = active video
- frame_start  in  1  one-cycle pulse once per frame, during vertical blanking
- pos_x  in  10  requested sprite left edge (screen pixels)
- pos_y  in  10  requested sprite top edge
- flip_x  in  1  requested horizontal mirror
- anim_en  in  1  requested animation enable
- rom_address  out  ADDR_W  to sprite ROM; combinational; ROM registers it (1-cycle read)
- rom_q  in  IDX_W  ROM data, valid one cycle after rom_address
- pix_idx  out  IDX_W  palette index of the sprite pixel
- pix_on  out  1  1 = opaque sprite pixel present
- frame_num  out  $clog2(FRAMES)  current animation frame

## Operation
- Shadow registers (pos_x_s, pos_y_s, flip_s, anim_s) load from the inputs only on a cycle where frame_start=1. Mid-frame input changes are ignored until the next pulse.
- Animation: on frame_start with anim_s=1 (the value before the load), div_cnt increments. At ANIM_DIV-1, div_cnt wraps to 0 and frame_num advances, wrapping from FRAMES-1 to 0. With anim_s=0, div_cnt and frame_num hold.
- Hit test: computed combinationally from DrawX/DrawY. dx = {1'b0,DrawX} - {1'b0,pos_x_s} in 11-bit two's complement; dy is formed the same way. hit = dx≥0, dx < SPR_W<<SCALE_SHIFT, dy≥0, and dy < SPR_H<<SCALE_SHIFT. No wrap-around: a sprite extending past column 1023 produces no hits at the left edge.
- Texel: col = dx>>SCALE_SHIFT; if flip_s, col = SPR_W-1-col. row = dy>>SCALE_SHIFT.
- rom_address = frame_num*SPR_W*SPR_H + row*SPR_W + col when hit, else 0.
- Stage 1 register: hit_d <= hit & blank.
- Stage 2 register: pix_on <= hit_d & (rom_q != TRANSP_IDX); pix_idx <= pix_on-next ? rom_q : 0.
- Reset: all of the following go to 0 on the first rising edge with Reset=1 and hold while Reset=1: shadow registers, div_cnt, frame_num, hit_d, pix_on, pix_idx. Reset mid-line or mid-frame clears everything in the same way. The sprite is then hidden at (0,0) with frame 0 until the next frame_start.

## Timing
- Latency is 2 cycles. The DrawX/DrawY/blank values presented in cycle t produce pix_on/pix_idx in cycle t+2. The compositor delays its own scan coordinates by 2 to match.
- Throughput is one pixel per cycle with no stalls.
- frame_start and a position update in the same cycle: the new position is used from the next cycle onward.
- A frame_start that causes a frame_num advance affects rom_address from the next cycle. Because frame_start occurs in vertical blanking, no visible pixel ever mixes frames.
- Changing frame_num, flip or position never produces a partial-frame artifact.

## Test plan
- Reset: assert Reset for 2 cycles at DrawX=100 → pix_on=0, pix_idx=0, frame_num=0, rom_address=0 (shadow pos (0,0) with DrawX=100 is a miss).
- Placement and latency: pos=(100,50), frame_start, scan row 50 → rom_address=0 at DrawX=100 and 31 at DrawX=131. pix_on tracks ROM opacity 2 cycles later. pix_on=0 at DrawX=99 and 132.
- Flip, transparency and scale (SCALE_SHIFT=1 build): flip_x=1, pos=(0,0) → DrawX=0 and 1 both address col 31; DrawX=63 addresses col 0. A ROM word equal to TRANSP_IDX gives pix_on=0, pix_idx=0.
- Animation: anim_en=1, ANIM_DIV=8, FRAMES=2 → frame_num toggles every 8 frame_start pulses; frame-1 address at pos origin = 1024. With anim_en=0, frame_num holds.
- Shadow latch and edge cases: change pos_x mid-line → output is unchanged until the next frame_start. pos_x=1010 → no hits at DrawX 0–20. blank=0 inside the sprite → pix_on=0. Reset asserted mid-sprite → pix_on=0 in the following cycle.

Source files
------------

// File: rtl/sprite_layer_renderer.sv
// Sprite layer: per-frame latched position/mode, hit test and texel addressing,
// two-stage pipeline aligned with a one-cycle registered sprite ROM.
module sprite_layer_renderer #(
  parameter int SPR_W       = 32,
  parameter int SPR_H       = 32,
  parameter int FRAMES      = 2,
  parameter int IDX_W       = 3,
  parameter int ADDR_W      = 11,
  parameter int SCALE_SHIFT = 0,
  parameter int ANIM_DIV    = 8,
  parameter int TRANSP_IDX  = 0
) (
  input  logic                                           vga_clk,
  input  logic                                           Reset,
  input  logic [9:0]                                     DrawX,
  input  logic [9:0]                                     DrawY,
  input  logic                                           blank,
  input  logic                                           frame_start,
  input  logic [9:0]                                     pos_x,
  input  logic [9:0]                                     pos_y,
  input  logic                                           flip_x,
  input  logic                                           anim_en,
  output logic [ADDR_W-1:0]                              rom_address,
  input  logic [IDX_W-1:0]                               rom_q,
  output logic [IDX_W-1:0]                               pix_idx,
  output logic                                           pix_on,
  output logic [((FRAMES > 1) ? $clog2(FRAMES) : 1)-1:0] frame_num
);

  localparam int FW = (FRAMES > 1) ? $clog2(FRAMES) : 1;
  localparam int DW = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;
  localparam int CW = $clog2(SPR_W);
  localparam int RW = $clog2(SPR_H);
  localparam logic [10:0] X_SPAN = 11'(SPR_W << SCALE_SHIFT);
  localparam logic [10:0] Y_SPAN = 11'(SPR_H << SCALE_SHIFT);

  logic [9:0]    pos_x_s;
  logic [9:0]    pos_y_s;
  logic          flip_s;
  logic          anim_s;
  logic [DW-1:0] div_cnt;
  logic          hit_d;

  logic [10:0]   dx;
  logic [10:0]   dy;
  logic          hit;
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic          pix_on_next;

  // Shadow registers and animation counter only move on frame_start;
  // the counter advances on the pre-load anim_s value.
  always_ff @(posedge vga_clk) begin
    if (Reset) begin
      pos_x_s   <= '0;
      pos_y_s   <= '0;
      flip_s    <= 1'b0;
      anim_s    <= 1'b0;
      div_cnt   <= '0;
      frame_num <= '0;
    end else if (frame_start) begin
      pos_x_s <= pos_x;
      pos_y_s <= pos_y;
      flip_s  <= flip_x;
      anim_s  <= anim_en;
      if (anim_s) begin
        if (div_cnt == DW'(ANIM_DIV - 1)) begin
          div_cnt   <= '0;
          frame_num <= (frame_num == FW'(FRAMES - 1)) ? '0 : frame_num + 1'b1;
        end else begin
          div_cnt <= div_cnt + 1'b1;
        end
      end
    end
  end

  always_comb begin
    dx  = {1'b0, DrawX} - {1'b0, pos_x_s};
    dy  = {1'b0, DrawY} - {1'b0, pos_y_s};
    hit = !dx[10] && (dx < X_SPAN) && !dy[10] && (dy < Y_SPAN);
    col = CW'(dx >> SCALE_SHIFT);
    row = RW'(dy >> SCALE_SHIFT);
    // SPR_W is a power of two, so SPR_W-1-col is the bitwise complement.
    if (flip_s) col = ~col;
    rom_address = hit ? ADDR_W'({frame_num, row, col}) : '0;
  end

  always_comb begin
    pix_on_next = hit_d && (rom_q != IDX_W'(TRANSP_IDX));
  end

  always_ff @(posedge vga_clk) begin
    if (Reset) begin
      hit_d   <= 1'b0;
      pix_on  <= 1'b0;
      pix_idx <= '0;
    end else begin
      hit_d   <= hit & blank;
      pix_on  <= pix_on_next;
      pix_idx <= pix_on_next ? rom_q : '0;
    end
  end

endmodule

// File: tb/tb_sprite_layer_renderer.sv
// Bench for sprite_layer_renderer: unscaled and 2x-scaled instances sharing
// stimulus, each fed by a registered ROM model holding (address mod 7).
module tb_sprite_layer_renderer;

  logic        vga_clk = 1'b0;
  logic        Reset, blank, frame_start, flip_x, anim_en;
  logic [9:0]  DrawX, DrawY, pos_x, pos_y;
  logic [10:0] addr_a, addr_b;
  logic [2:0]  q_a, q_b, idx_a, idx_b;
  logic        on_a, on_b, fn_a, fn_b;

  int checks   = 0;
  int failures = 0;

  always #5 vga_clk = ~vga_clk;

  sprite_layer_renderer #(.SCALE_SHIFT(0)) u_a (
    .vga_clk(vga_clk), .Reset(Reset), .DrawX(DrawX), .DrawY(DrawY), .blank(blank),
    .frame_start(frame_start), .pos_x(pos_x), .pos_y(pos_y), .flip_x(flip_x),
    .anim_en(anim_en), .rom_address(addr_a), .rom_q(q_a), .pix_idx(idx_a),
    .pix_on(on_a), .frame_num(fn_a));

  sprite_layer_renderer #(.SCALE_SHIFT(1)) u_b (
    .vga_clk(vga_clk), .Reset(Reset), .DrawX(DrawX), .DrawY(DrawY), .blank(blank),
    .frame_start(frame_start), .pos_x(pos_x), .pos_y(pos_y), .flip_x(flip_x),
    .anim_en(anim_en), .rom_address(addr_b), .rom_q(q_b), .pix_idx(idx_b),
    .pix_on(on_b), .frame_num(fn_b));

  function automatic logic [2:0] rom_val(input logic [10:0] a);
    return 3'(a % 7);
  endfunction

  always @(posedge vga_clk) begin
    q_a <= rom_val(addr_a);
    q_b <= rom_val(addr_b);
  end

  // Returns -1 on a miss, otherwise the texel address.
  function automatic int model_addr(input int x, input int y, input int px, input int py,
                                    input int s, input bit fl, input int fr);
    int dx, dy, col, row;
    dx = x - px;
    dy = y - py;
    if (dx < 0 || dx >= (32 << s) || dy < 0 || dy >= (32 << s)) return -1;
    col = dx >> s;
    if (fl) col = 31 - col;
    row = dy >> s;
    return fr * 1024 + row * 32 + col;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge vga_clk);
    #1;
  endtask

  task automatic pulse();
    frame_start = 1'b1;
    tick(1);
    frame_start = 1'b0;
  endtask

  task automatic put(input int x, input int y);
    DrawX = 10'(x);
    DrawY = 10'(y);
    #1;
  endtask

  typedef struct {
    int x;
    int y;
    bit b;
    int addr;
    bit on;
    int idx;
  } vec_t;

  vec_t tv[11];
  int   hist[$];
  int   e, ep;
  bit   eon;

  initial begin
    // pos (100,50), frame 0, no flip; ROM word = address mod 7
    tv[0]  = '{100, 50, 1'b1,    0, 1'b0, 0};
    tv[1]  = '{131, 50, 1'b1,   31, 1'b1, 3};
    tv[2]  = '{ 99, 50, 1'b1,    0, 1'b0, 0};
    tv[3]  = '{132, 50, 1'b1,    0, 1'b0, 0};
    tv[4]  = '{101, 50, 1'b1,    1, 1'b1, 1};
    tv[5]  = '{110, 60, 1'b1,  330, 1'b1, 1};
    tv[6]  = '{115, 81, 1'b1, 1007, 1'b1, 6};
    tv[7]  = '{115, 82, 1'b1,    0, 1'b0, 0};
    tv[8]  = '{115, 49, 1'b1,    0, 1'b0, 0};
    tv[9]  = '{120, 55, 1'b0,  180, 1'b0, 0};
    tv[10] = '{107, 50, 1'b1,    7, 1'b0, 0};

    Reset = 1'b1; blank = 1'b1; frame_start = 1'b0; flip_x = 1'b0; anim_en = 1'b0;
    pos_x = 10'd100; pos_y = 10'd50; DrawX = 10'd100; DrawY = 10'd50;
    tick(2);
    chk("reset_pix_on", on_a, 0);
    chk("reset_pix_idx", idx_a, 0);
    chk("reset_frame_num", fn_a, 0);
    chk("reset_rom_address", addr_a, 0);
    Reset = 1'b0;
    tick(1);
    pulse();

    foreach (tv[i]) begin
      DrawX = 10'(tv[i].x);
      DrawY = 10'(tv[i].y);
      blank = tv[i].b;
      tick(3);
      chk($sformatf("vec%0d_addr", i), addr_a, tv[i].addr);
      chk($sformatf("vec%0d_on", i), on_a, tv[i].on);
      chk($sformatf("vec%0d_idx", i), idx_a, tv[i].idx);
    end

    // Streaming scan of row 50: outputs lag the coordinates by exactly 2 cycles.
    blank = 1'b1;
    for (int x = 97; x <= 134; x++) begin
      put(x, 50);
      e = model_addr(x, 50, 100, 50, 0, 1'b0, 0);
      chk($sformatf("stream_addr_x%0d", x), addr_a, (e < 0) ? 0 : e);
      if (hist.size() >= 2) begin
        ep  = hist[hist.size() - 2];
        eon = (ep >= 0) && (rom_val(11'(ep)) != 3'd0);
        chk($sformatf("stream_on_x%0d", x - 2), on_a, eon);
        chk($sformatf("stream_idx_x%0d", x - 2), idx_a, eon ? rom_val(11'(ep)) : 3'd0);
      end
      hist.push_back(e);
      @(posedge vga_clk);
      #0;
    end
    tick(1);

    // Shadow latch: mid-line pos_x change has no effect until frame_start.
    put(105, 50);
    tick(3);
    chk("shadow_before_addr", addr_a, 5);
    chk("shadow_before_on", on_a, 1);
    pos_x = 10'd200;
    tick(3);
    chk("shadow_hold_addr", addr_a, 5);
    chk("shadow_hold_idx", idx_a, 5);
    frame_start = 1'b1;
    #1;
    chk("shadow_load_cycle_addr", addr_a, 5);
    tick(1);
    frame_start = 1'b0;
    chk("shadow_after_old_addr", addr_a, 0);
    put(205, 50);
    chk("shadow_after_new_addr", addr_a, 5);

    // No wrap-around past column 1023.
    pos_x = 10'd1010;
    pulse();
    for (int x = 0; x <= 20; x++) begin
      put(x, 50);
      chk($sformatf("nowrap_addr_x%0d", x), addr_a, 0);
    end
    tick(3);
    chk("nowrap_on", on_a, 0);
    put(1015, 50);
    chk("edge_right_addr", addr_a, 5);
    pos_x = 10'd100;
    pulse();

    // Animation: first pulse only loads anim_s; frame advances on the 8th count.
    anim_en = 1'b1;
    pulse();
    repeat (7) pulse();
    chk("anim_pre_toggle", fn_a, 0);
    pulse();
    chk("anim_toggle", fn_a, 1);
    put(100, 50);
    chk("anim_frame1_addr", addr_a, 1024);
    put(101, 50);
    tick(3);
    chk("anim_frame1_idx", idx_a, 3);
    anim_en = 1'b0;
    pulse();
    repeat (12) pulse();
    chk("anim_hold", fn_a, 1);
    anim_en = 1'b1;
    pulse();
    repeat (6) pulse();
    chk("anim_resume_pre", fn_a, 1);
    pulse();
    chk("anim_resume_wrap", fn_a, 0);
    anim_en = 1'b0;
    pulse();

    // Flip, with the 2x-scaled instance.
    pos_x = 10'd0; pos_y = 10'd0; flip_x = 1'b1;
    pulse();
    put(0, 0);
    chk("flip_b_x0", addr_b, 31);
    chk("flip_a_x0", addr_a, 31);
    put(1, 0);
    chk("flip_b_x1", addr_b, 31);
    chk("flip_a_x1", addr_a, 30);
    put(2, 0);
    chk("flip_b_x2", addr_b, 30);
    put(63, 0);
    chk("flip_b_x63", addr_b, 0);
    put(31, 0);
    chk("flip_a_x31", addr_a, 0);
    put(32, 0);
    chk("flip_a_x32_miss", addr_a, 0);
    put(0, 3);
    chk("flip_b_row1", addr_b, 63);
    put(0, 0);
    tick(3);
    chk("scale_on_opaque", on_b, 1);
    chk("scale_idx_opaque", idx_b, 3);
    put(63, 0);
    tick(3);
    chk("scale_on_transp", on_b, 0);
    chk("scale_idx_transp", idx_b, 0);

    // Reset in the middle of an opaque run.
    pos_x = 10'd100; pos_y = 10'd50; flip_x = 1'b0;
    pulse();
    put(101, 50);
    tick(3);
    chk("midreset_pre_on", on_a, 1);
    Reset = 1'b1;
    tick(1);
    chk("midreset_on", on_a, 0);
    chk("midreset_idx", idx_a, 0);
    Reset = 1'b0;
    tick(3);
    chk("midreset_after_addr", addr_a, 0);
    chk("midreset_after_on", on_a, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
